// File: rtl/conv3x3_pipe_ctrl.sv
// Sequencing controller for the 3x3 FP32 multiply/adder-tree pipeline: tracks the raster
// position of each pixel, issues stage enables and handshakes the tree result downstream.
module conv3x3_pipe_ctrl #(
    parameter int unsigned IMG_W  = 224,
    parameter int unsigned IMG_H  = 224,
    parameter int unsigned CNT_W  = 9,
    parameter int unsigned OCNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       valid_in,
    output logic [3:0] valid_pipeline2D,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_t;

    localparam int unsigned NumWin = (IMG_W - 2) * (IMG_H - 2);
    localparam logic [CNT_W-1:0] ColLast = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] RowLast = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] WinMin = CNT_W'(2);
    localparam logic [OCNT_W-1:0] OutLast = OCNT_W'(NumWin - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [3:0]        occ_q, occ_d;
    logic              out_valid_q, out_valid_d;
    logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;

    logic stall;
    logic accept;
    logic last_pix;
    logic handshake;

    always_comb begin
        stall            = out_valid_q & ~out_ready;
        in_ready         = (state_q == StRun) & ~stall;
        accept           = in_valid & in_ready;
        last_pix         = accept & (row_q == RowLast) & (col_q == ColLast);
        // Pre-increment counters: the window completed by this pixel enters the tree now.
        valid_in         = accept & (row_q >= WinMin) & (col_q >= WinMin);
        valid_pipeline2D = occ_q & {4{~stall}};
        handshake        = out_valid_q & out_ready;
        out_valid        = out_valid_q;
        out_last         = out_valid_q & (out_cnt_q == OutLast);
        busy             = (state_q != StIdle);
        done             = (state_q == StDone);
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        occ_d       = occ_q;
        out_valid_d = out_valid_q;
        out_cnt_d   = out_cnt_q;

        if (!stall) begin
            occ_d       = {occ_q[2:0], valid_in};
            out_valid_d = occ_q[3];
        end
        if (handshake) begin
            out_cnt_d = out_cnt_q + OCNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    row_d     = '0;
                    col_d     = '0;
                    out_cnt_d = '0;
                end
            end
            StRun: begin
                if (last_pix) begin
                    state_d = StFlush;
                end else if (accept) begin
                    if (col_q == ColLast) begin
                        col_d = '0;
                        row_d = row_q + CNT_W'(1);
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end
            StFlush: begin
                if ((occ_q == 4'b0000) && (!out_valid_q || out_ready)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

endmodule
